// File: rtl/life_datapath_param.sv
// Parametrised single-clock Game of Life datapath: edit, step, count, stable/extinct detection.
// Optional macro AUTO_HALT_EN: freezes stepping once a step yields a still-life or empty grid.
module life_datapath_param #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned WRAP  = 0,
    parameter int unsigned GEN_W = 16
) (
    input  logic                           clka,
    input  logic                           rst_n,
    input  logic [1:0]                     mode,
    input  logic                           tick,
    input  logic                           btn0,
    input  logic                           btn1,
    input  logic                           stop,
    output logic [ROWS*COLS-1:0]           grid,
    output logic [$clog2(ROWS*COLS)-1:0]   cursor,
    output logic [GEN_W-1:0]               gen_count,
    output logic                           stable,
    output logic                           extinct,
    output logic                           halted
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned CW = $clog2(N);

    localparam logic [1:0] ModeClear = 2'b00;
    localparam logic [1:0] ModeEdit  = 2'b01;
    localparam logic [1:0] ModePlay  = 2'b10;

    logic [N-1:0]     grid_q, grid_d, grid_nxt;
    logic [CW-1:0]    cursor_q, cursor_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;
    logic             halted_q, halted_d;

    // One rule evaluator per cell; out-of-grid neighbours read as dead unless WRAP is set.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned RU = (r == 0) ? ROWS - 1 : r - 1;
            localparam int unsigned RD = (r == ROWS - 1) ? 0 : r + 1;
            localparam int unsigned CL = (c == 0) ? COLS - 1 : c - 1;
            localparam int unsigned CR = (c == COLS - 1) ? 0 : c + 1;
            localparam bit VU = (WRAP != 0) || (r > 0);
            localparam bit VD = (WRAP != 0) || (r < ROWS - 1);
            localparam bit VL = (WRAP != 0) || (c > 0);
            localparam bit VR = (WRAP != 0) || (c < COLS - 1);

            logic [7:0] nb;
            logic [3:0] cnt;

            assign nb[0] = VU && VL && grid_q[RU*COLS+CL];
            assign nb[1] = VU && grid_q[RU*COLS+c];
            assign nb[2] = VU && VR && grid_q[RU*COLS+CR];
            assign nb[3] = VL && grid_q[r*COLS+CL];
            assign nb[4] = VR && grid_q[r*COLS+CR];
            assign nb[5] = VD && VL && grid_q[RD*COLS+CL];
            assign nb[6] = VD && grid_q[RD*COLS+c];
            assign nb[7] = VD && VR && grid_q[RD*COLS+CR];

            always_comb begin
                cnt = '0;
                for (int k = 0; k < 8; k++) begin
                    cnt = cnt + {3'b000, nb[k]};
                end
            end

            assign grid_nxt[r*COLS+c] = (cnt == 4'd3) || (grid_q[r*COLS+c] && (cnt == 4'd2));
        end
    end

    always_comb begin
        grid_d    = grid_q;
        cursor_d  = cursor_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        halted_d  = 1'b0;
        extinct_d = (grid_q == '0) && (mode == ModePlay);
        unique case (mode)
            ModeClear: begin
                grid_d    = '0;
                cursor_d  = '0;
                gen_d     = '0;
                stable_d  = 1'b0;
                extinct_d = 1'b0;
            end
            ModeEdit: begin
                if (tick && (btn0 ^ btn1)) begin
                    grid_d[cursor_q] = btn0;
                    cursor_d = (cursor_q == CW'(N - 1)) ? '0 : cursor_q + 1'b1;
                    stable_d = 1'b0;
                end
            end
            ModePlay: begin
                halted_d = halted_q;
                if (tick && !stop && !halted_q) begin
                    grid_d   = grid_nxt;
                    stable_d = (grid_nxt == grid_q);
                    if (gen_q != '1) begin
                        gen_d = gen_q + 1'b1;
                    end
`ifdef AUTO_HALT_EN
                    halted_d = (grid_nxt == grid_q) || (grid_nxt == '0);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            grid_q    <= '0;
            cursor_q  <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            grid_q    <= grid_d;
            cursor_q  <= cursor_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
            halted_q  <= halted_d;
        end
    end

    assign grid      = grid_q;
    assign cursor    = cursor_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_life_datapath_param.sv
// Directed bench for life_datapath_param (8x8); a second instance covers WRAP=1.
module tb_life_datapath_param;

    logic        clka = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        tick, btn0, btn1, stop;
    logic [63:0] grid, grid_w;
    logic [5:0]  cursor, cursor_w;
    logic [15:0] gen_count, gen_count_w;
    logic        stable, extinct, halted;
    logic        stable_w, extinct_w, halted_w;

    int passed = 0;
    int total  = 0;

`ifdef AUTO_HALT_EN
    localparam bit AutoHalt = 1'b1;
`else
    localparam bit AutoHalt = 1'b0;
`endif

    always #5 clka = ~clka;

    life_datapath_param #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) dut (
        .clka(clka), .rst_n(rst_n), .mode(mode), .tick(tick), .btn0(btn0), .btn1(btn1),
        .stop(stop), .grid(grid), .cursor(cursor), .gen_count(gen_count), .stable(stable),
        .extinct(extinct), .halted(halted)
    );

    life_datapath_param #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) dut_w (
        .clka(clka), .rst_n(rst_n), .mode(mode), .tick(tick), .btn0(btn0), .btn1(btn1),
        .stop(stop), .grid(grid_w), .cursor(cursor_w), .gen_count(gen_count_w),
        .stable(stable_w), .extinct(extinct_w), .halted(halted_w)
    );

    task automatic clk();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic ed(input logic b0, input logic b1);
        mode = 2'b01; btn0 = b0; btn1 = b1; tick = 1'b1;
        clk();
        tick = 1'b0; btn0 = 1'b0; btn1 = 1'b0;
    endtask

    task automatic clr();
        mode = 2'b00; tick = 1'b0;
        clk();
    endtask

    task automatic play();
        mode = 2'b10; tick = 1'b1;
        clk();
        tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; tick = 1'b0; btn0 = 1'b0; btn1 = 1'b0; stop = 1'b0;
        clk(); clk();
        rst_n = 1'b1;
        chk("rst_grid", grid, 64'd0);
        chk("rst_cursor", 64'(cursor), 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_stable", 64'(stable), 64'd0);
        chk("rst_extinct", 64'(extinct), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);

        // Reset wins over a simultaneous edit tick.
        for (int i = 0; i < 6; i++) ed(1'b1, 1'b0);
        chk("load_grid", grid, 64'h3F);
        chk("load_cursor", 64'(cursor), 64'd6);
        rst_n = 1'b0; mode = 2'b01; btn0 = 1'b1; tick = 1'b1;
        clk();
        rst_n = 1'b1; tick = 1'b0; btn0 = 1'b0;
        chk("rst2_grid", grid, 64'd0);
        chk("rst2_cursor", 64'(cursor), 64'd0);

        for (int i = 0; i < 6; i++) ed(1'b1, 1'b0);
        clr();
        chk("clr_grid", grid, 64'd0);
        chk("clr_cursor", 64'(cursor), 64'd0);
        chk("clr_gen", 64'(gen_count), 64'd0);

        // Edit sequence, ending with an ignored double press.
        ed(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) ed(1'b0, 1'b1);
        ed(1'b1, 1'b0); ed(1'b0, 1'b1); ed(1'b1, 1'b0); ed(1'b1, 1'b0);
        ed(1'b0, 1'b1); ed(1'b0, 1'b1); ed(1'b1, 1'b1);
        chk("edit_grid", grid, 64'h341);
        chk("edit_cursor", 64'(cursor), 64'd12);

        // Blinker: row 1 cols 1..3 <-> col 2 rows 0..2.
        clr();
        for (int i = 0; i < 9; i++) ed(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) ed(1'b1, 1'b0);
        play();
        chk("blink1_grid", grid, 64'h40404);
        chk("blink1_gen", 64'(gen_count), 64'd1);
        chk("blink1_stable", 64'(stable), 64'd0);
        play();
        chk("blink2_grid", grid, 64'hE00);
        chk("blink2_gen", 64'(gen_count), 64'd2);
        chk("blink2_extinct", 64'(extinct), 64'd0);

        // Block still-life.
        clr();
        ed(1'b1, 1'b0); ed(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) ed(1'b0, 1'b1);
        ed(1'b1, 1'b0); ed(1'b1, 1'b0);
        play();
        chk("block_stable", 64'(stable), 64'd1);
        chk("block_gen1", 64'(gen_count), 64'd1);
        chk("block_halt1", 64'(halted), 64'(AutoHalt));
        for (int i = 0; i < 5; i++) play();
        chk("block_gen6", 64'(gen_count), AutoHalt ? 64'd1 : 64'd6);
        chk("block_grid", grid, 64'h303);
        mode = 2'b11;
        clk();
        chk("pause_halt_clr", 64'(halted), 64'd0);
        chk("pause_stable_keep", 64'(stable), 64'd1);

        // Lone cell at 27: stop inhibits, then it dies.
        clr();
        for (int i = 0; i < 27; i++) ed(1'b0, 1'b1);
        ed(1'b1, 1'b0);
        stop = 1'b1;
        for (int i = 0; i < 3; i++) play();
        chk("stop_grid", grid, 64'h1 << 27);
        chk("stop_gen", 64'(gen_count), 64'd0);
        stop = 1'b0;
        play();
        chk("die_grid", grid, 64'd0);
        chk("die_gen", 64'(gen_count), 64'd1);
        chk("die_extinct_lag", 64'(extinct), 64'd0);
        chk("die_halt", 64'(halted), 64'(AutoHalt));
        clk();
        chk("die_extinct", 64'(extinct), 64'd1);

        // Row-0 blinker straddling the column seam.
        clr();
        ed(1'b1, 1'b0); ed(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) ed(1'b0, 1'b1);
        ed(1'b1, 1'b0);
        chk("seam_load", grid_w, 64'h83);
        play();
        chk("wrap_grid", grid_w, (64'h1 << 56) | 64'h101);
        chk("nowrap_grid", grid, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
